// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR filter: one shared multiplier-accumulator walks the taps, valid/ready on both sides.
// Optional build macro FIR_SYMMETRIC_EN: store ceil(TAPS/2) coefficients and pre-add mirrored samples.
module fir_serial_mac #(
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int TAPS      = 19,
  parameter int OUT_W     = 16,
  parameter int OUT_SHIFT = 19
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    coef_we,
  input  logic [$clog2(TAPS)-1:0] coef_addr,
  input  logic [COEF_W-1:0]       coef_wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        data_out,
  output logic                    busy
);

  localparam int ACC_W = DATA_W + COEF_W + $clog2(TAPS) + 1;
  localparam int IDX_W = $clog2(TAPS);
`ifdef FIR_SYMMETRIC_EN
  localparam int NCOEF = (TAPS + 1) / 2;
  localparam int PRE_W = DATA_W + 1;
`else
  localparam int NCOEF = TAPS;
  localparam int PRE_W = DATA_W;
`endif
  localparam int PROD_W = PRE_W + COEF_W;
  localparam int RND_W  = ACC_W + 1;

  localparam logic signed [RND_W-1:0] RND_HALF = RND_W'(1) << (OUT_SHIFT - 1);
  localparam logic signed [RND_W-1:0] SAT_MAX  = {{(RND_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [RND_W-1:0] SAT_MIN  = {{(RND_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_ROUND, S_OUT} state_e;

  // Low-pass set used when the filter is built at its original 19-tap size.
  function automatic logic [COEF_W-1:0] coef_reset(input int i);
    int k;
    if (TAPS != 19) return '0;
    k = (i > 9) ? 18 - i : i;
    case (k)
      0:       return COEF_W'(26);
      1:       return COEF_W'(270);
      2:       return COEF_W'(963);
      3:       return COEF_W'(2424);
      4:       return COEF_W'(4869);
      5:       return COEF_W'(8259);
      6:       return COEF_W'(12194);
      7:       return COEF_W'(15948);
      8:       return COEF_W'(18666);
      9:       return COEF_W'(19660);
      default: return '0;
    endcase
  endfunction

  state_e                    state_q;
  logic [IDX_W-1:0]          idx_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [DATA_W-1:0]  x_q    [TAPS];
  logic signed [COEF_W-1:0]  coef_q [TAPS];
  logic                      out_valid_q;
  logic [OUT_W-1:0]          data_out_q;

  logic signed [PRE_W-1:0]   pre;
  logic signed [PROD_W-1:0]  prod;
  logic signed [ACC_W-1:0]   acc_d;
  logic signed [RND_W-1:0]   rnd_sum;
  logic signed [RND_W-1:0]   shifted;
  logic [OUT_W-1:0]          sat_d;
`ifdef FIR_SYMMETRIC_EN
  logic [IDX_W-1:0]          mirror;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
`ifdef FIR_SYMMETRIC_EN
    mirror = IDX_W'(TAPS - 1) - idx_q;
    pre    = {x_q[idx_q][DATA_W-1], x_q[idx_q]};
    if (mirror != idx_q)
      pre = {x_q[idx_q][DATA_W-1], x_q[idx_q]} + {x_q[mirror][DATA_W-1], x_q[mirror]};
`else
    pre = x_q[idx_q];
`endif
    prod  = pre * coef_q[idx_q];
    acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // Round half up, then floor-shift; saturate into the output range.
    rnd_sum = {acc_q[ACC_W-1], acc_q} + RND_HALF;
    shifted = rnd_sum >>> OUT_SHIFT;
    sat_d   = shifted[OUT_W-1:0];
    if (shifted > SAT_MAX)      sat_d = SAT_MAX[OUT_W-1:0];
    else if (shifted < SAT_MIN) sat_d = SAT_MIN[OUT_W-1:0];
  end

  // NOTE: coefficients are registers (not RAM) because they must return to their defaults on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        x_q[i]    <= '0;
        coef_q[i] <= coef_reset(i);
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (coef_we && (int'(coef_addr) < NCOEF))
            coef_q[coef_addr] <= coef_wdata;
          if (in_valid) begin
            x_q[0] <= data_in;
            for (int i = 1; i < TAPS; i++) x_q[i] <= x_q[i-1];
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= S_MAC;
          end
        end
        S_MAC: begin
          acc_q <= acc_d;
          if (idx_q == IDX_W'(NCOEF - 1)) state_q <= S_ROUND;
          else                            idx_q   <= idx_q + 1'b1;
        end
        S_ROUND: begin
          data_out_q  <= sat_d;
          out_valid_q <= 1'b1;
          state_q     <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_fir_serial_mac.sv
// Self-checking bench for fir_serial_mac: random and directed stimulus against a sum-of-products model.
module tb_fir_serial_mac;

  localparam int DATA_W    = 16;
  localparam int COEF_W    = 16;
  localparam int TAPS      = 19;
  localparam int OUT_W     = 16;
  localparam int OUT_SHIFT = 19;
  localparam int AW        = $clog2(TAPS);
`ifdef FIR_SYMMETRIC_EN
  localparam int NC = (TAPS + 1) / 2;
`else
  localparam int NC = TAPS;
`endif
  localparam int LAT   = NC + 1;
  localparam int Y_MAX = 2 ** (OUT_W - 1) - 1;
  localparam int Y_MIN = -(2 ** (OUT_W - 1));

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid, in_ready, coef_we, out_valid, out_ready, busy;
  logic [DATA_W-1:0] data_in;
  logic [AW-1:0]     coef_addr;
  logic [COEF_W-1:0] coef_wdata;
  logic [OUT_W-1:0]  data_out;

  int tests_run    = 0;
  int tests_failed = 0;

  int hist   [TAPS];
  int coef_m [TAPS];
  int mac_we_cycle = -1;
  int gate_addr    = 0;
  int gate_data    = 0;

  fir_serial_mac #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .OUT_W(OUT_W), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int default_coef(input int i);
    int tbl [10] = '{26, 270, 963, 2424, 4869, 8259, 12194, 15948, 18666, 19660};
    return (i < 10) ? tbl[i] : tbl[TAPS - 1 - i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      hist[i]   = 0;
      coef_m[i] = default_coef(i);
    end
  endtask

  task automatic model_push(input int s);
    for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = s;
  endtask

  task automatic model_write(input int a, input int v);
    if (a < NC) begin
      coef_m[a] = v;
`ifdef FIR_SYMMETRIC_EN
      coef_m[TAPS - 1 - a] = v;
`endif
    end
  endtask

  function automatic int model_out();
    longint acc = 0;
    for (int i = 0; i < TAPS; i++) acc += longint'(hist[i]) * longint'(coef_m[i]);
    acc = (acc + (longint'(1) <<< (OUT_SHIFT - 1))) >>> OUT_SHIFT;
    if (acc > Y_MAX) return Y_MAX;
    if (acc < Y_MIN) return Y_MIN;
    return int'(acc);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic apply_reset();
    in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    data_in = '0; coef_addr = '0; coef_wdata = '0;
    #2 reset = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic write_coef(input int a, input int v);
    coef_we = 1'b1; coef_addr = AW'(a); coef_wdata = COEF_W'(v);
    @(posedge clk); #1;
    coef_we = 1'b0;
    model_write(a, v);
  endtask

  // Sends one sample, compares result and latency, and completes the output transfer.
  task automatic send_sample(input int s, input int hold, output int y);
    int waitc;
    int lat;
    int exp_y;
    y = 0;
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    data_in   = DATA_W'(s);
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 1000) begin
      @(posedge clk); #1; waitc++;
    end
    if (in_ready !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL accept_timeout: in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    data_in  = '0;
    model_push(s);
    exp_y = model_out();
    lat = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1; lat++;
      if (lat == mac_we_cycle) begin
        coef_we = 1'b1; coef_addr = AW'(gate_addr); coef_wdata = COEF_W'(gate_data);
      end else begin
        coef_we = 1'b0;
      end
    end
    coef_we = 1'b0;
    tests_run++;
    if (lat !== LAT) begin
      tests_failed++;
      $display("FAIL latency: got %0d cycles required %0d", lat, LAT);
    end
    y = int'($signed(data_out));
    tests_run++;
    if (data_out !== OUT_W'(exp_y)) begin
      tests_failed++;
      $display("FAIL data_out: sample %0d got %0d required %0d", s, y, exp_y);
    end
    repeat (hold) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL transfer: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    in_valid = 1'b0; coef_we = 1'b0; out_ready = 1'b1;
    data_in = '0; coef_addr = '0; coef_wdata = '0;
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    #3;
    tests_run++;
    if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
    tests_run++;
    if (data_out !== '0) begin tests_failed++; $display("FAIL rst_data_out: got %0d required 0", data_out); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b required 0", busy); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL idle_after_rst: busy=%b in_ready=%b required 0/1", busy, in_ready);
    end
  endtask

  task automatic test_impulse(input int centre_req);
    int ys [TAPS];
    int y;
    for (int j = 0; j < TAPS; j++) begin
      send_sample((j == 0) ? 32767 : 0, 0, y);
      ys[j] = y;
    end
    tests_run++;
    if (ys[0] !== 2) begin tests_failed++; $display("FAIL impulse_first: got %0d required 2", ys[0]); end
    tests_run++;
    if (ys[1] !== 17) begin tests_failed++; $display("FAIL impulse_tap1: got %0d required 17", ys[1]); end
    tests_run++;
    if (ys[2] !== 60) begin tests_failed++; $display("FAIL impulse_tap2: got %0d required 60", ys[2]); end
    tests_run++;
    if (ys[9] !== centre_req) begin
      tests_failed++; $display("FAIL impulse_centre: got %0d required %0d", ys[9], centre_req);
    end
    tests_run++;
    if (ys[18] !== 2) begin tests_failed++; $display("FAIL impulse_last: got %0d required 2", ys[18]); end
  endtask

  task automatic test_coef_gating();
    apply_reset();
    mac_we_cycle = 3; gate_addr = 9; gate_data = 0;
    test_impulse(1229);
    mac_we_cycle = -1;
    write_coef(9, 0);
    test_impulse(0);
    write_coef(TAPS + 5 < (1 << AW) ? TAPS + 5 : NC, 1000);
  endtask

  task automatic test_async_reset();
    int waitc;
    apply_reset();
    in_valid = 1'b1; data_in = DATA_W'(32767);
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 100) begin @(posedge clk); #1; waitc++; end
    @(posedge clk); #1;
    in_valid = 1'b0; data_in = '0;
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL mac_busy: got %b required 1", busy); end
    #2 reset = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL async_rst: busy=%b out_valid=%b in_ready=%b required 0/0/1", busy, out_valid, in_ready);
    end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    test_impulse(1229);
  endtask

  task automatic test_saturation();
    int y;
    for (int a = 0; a < NC; a++) write_coef(a, 32767);
    for (int j = 0; j < TAPS; j++) send_sample(32767, int'($urandom_range(2)), y);
    tests_run++;
    if (y !== Y_MAX) begin tests_failed++; $display("FAIL sat_pos: got %0d required %0d", y, Y_MAX); end
    for (int j = 0; j < TAPS; j++) send_sample(-32768, int'($urandom_range(2)), y);
    tests_run++;
    if (y !== Y_MIN) begin tests_failed++; $display("FAIL sat_neg: got %0d required %0d", y, Y_MIN); end
  endtask

  task automatic test_random();
    int y;
    for (int a = 0; a < NC; a++) write_coef(a, int'($urandom_range(8191)) - 4096);
    for (int j = 0; j < 40; j++)
      send_sample(int'($urandom_range(65535)) - 32768, int'($urandom_range(3)), y);
  endtask

  task automatic test_backpressure();
    int waitc;
    int exp_y;
    logic [OUT_W-1:0] held;
    bit ok;
    int y;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data_in   = DATA_W'(int'($urandom_range(65535)));
    waitc = 0;
    while (in_ready !== 1'b1 && waitc < 100) begin @(posedge clk); #1; waitc++; end
    @(posedge clk); #1;
    model_push(int'($signed(data_in)));
    exp_y = model_out();
    data_in = DATA_W'(12345);
    waitc = 0;
    while (out_valid !== 1'b1 && waitc < 200) begin @(posedge clk); #1; waitc++; end
    held = data_out;
    tests_run++;
    if (held !== OUT_W'(exp_y)) begin
      tests_failed++; $display("FAIL bp_value: got %0d required %0d", $signed(held), exp_y);
    end
    ok = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk); #1;
      if (data_out !== held || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
    end
    tests_run++;
    if (ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_hold: data_out=%0d out_valid=%b in_ready=%b required stable/1/0", data_out, out_valid, in_ready);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      tests_failed++; $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL bp_single: out_valid=%b busy=%b required 0/0", out_valid, busy);
    end
    for (int j = 0; j < 3; j++) send_sample(int'($urandom_range(65535)) - 32768, 0, y);
  endtask

  task automatic test_back_to_back();
    int y;
    for (int j = 0; j < 10; j++) send_sample(int'($urandom_range(65535)) - 32768, 0, y);
  endtask

  initial begin
    test_reset();
    test_impulse(1229);
    test_coef_gating();
    test_async_reset();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
